// File: rtl/zmon_pkg.sv
// Shared types and constants for the Z response monitor.
// The signature constants are used only when ZMON_SIGNATURE_EN is defined.
package zmon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  localparam int unsigned ZW_DEFAULT = 4;

  // x^16 + x^12 + x^5 + 1, MSB term implicit
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] din);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/zmon_exp_table.sv
// Expected-response table: DEPTH x Z_W register file with synchronous write
// and combinational read. Not reset, so contents survive a monitor reset.
module zmon_exp_table #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned Z_W   = 4,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [Z_W-1:0]   wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [Z_W-1:0]   rdata
);

  logic [Z_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/z_response_monitor.sv
// Samples z once per clock during a run and checks it against a preloaded table.
// Optional 16-bit MISR signature output when ZMON_SIGNATURE_EN is defined.
module z_response_monitor
  import zmon_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned Z_W   = ZW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_addr,
  input  logic [Z_W-1:0]   exp_data,
  input  logic             start,
  input  logic [Z_W-1:0]   z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   err_cnt,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [Z_W-1:0]   first_err_z
`ifdef ZMON_SIGNATURE_EN
  ,
  output logic [15:0]      sig
`endif
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [Z_W-1:0]   exp_z;
  logic             launch;
  logic             last;
  logic             mismatch;

  // Writes are blocked while capturing so the table is frozen for the run.
  zmon_exp_table #(
    .DEPTH (DEPTH),
    .Z_W   (Z_W),
    .IDX_W (IDX_W)
  ) u_table (
    .clk   (clk),
    .we    (exp_we && (state != CAPTURE)),
    .waddr (exp_addr),
    .wdata (exp_data),
    .raddr (idx),
    .rdata (exp_z)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = CAPTURE;
          launch    = 1'b1;
        end
      end
      CAPTURE: begin
        if (last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == CAPTURE);
  assign done     = (state == DONE);
  assign pass     = done && (err_cnt == '0);
  assign last     = busy && (idx == IDX_W'(DEPTH - 1));
  assign mismatch = busy && (z != exp_z);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_z   <= '0;
    end else if (launch) begin
      idx           <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_z   <= '0;
    end else if (busy) begin
      idx <= idx + 1'b1;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        // A zero count means this is the first mismatch of the run.
        if (err_cnt == '0) begin
          first_err_idx <= idx;
          first_err_z   <= z;
        end
      end
    end
  end

`ifdef ZMON_SIGNATURE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sig <= MISR_SEED;
    else if (launch) sig <= MISR_SEED;
    else if (busy)   sig <= misr_step(sig, 16'(z));
  end
`endif

endmodule
